// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, DR selection codes, default opcodes and
// the 1149.1 next-state function used by both the RTL and the formal harness.
package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR   = 4'h0,
        EXIT1_DR   = 4'h1,
        SHIFT_DR   = 4'h2,
        PAUSE_DR   = 4'h3,
        SELECT_IR  = 4'h4,
        UPDATE_DR  = 4'h5,
        CAPTURE_DR = 4'h6,
        SELECT_DR  = 4'h7,
        EXIT2_IR   = 4'h8,
        EXIT1_IR   = 4'h9,
        SHIFT_IR   = 4'hA,
        PAUSE_IR   = 4'hB,
        RUN_IDLE   = 4'hC,
        UPDATE_IR  = 4'hD,
        CAPTURE_IR = 4'hE,
        TEST_RESET = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

    localparam int          DEFAULT_IR_WIDTH   = 4;
    localparam int          DEFAULT_USER_WIDTH = 8;
    localparam int          DEFAULT_OP_IDCODE  = 1;
    localparam int          DEFAULT_OP_USER    = 2;
    localparam int          IDCODE_WIDTH       = 32;
    localparam logic [31:0] DEFAULT_IDCODE     = 32'h0000_FAF1;

    function automatic tap_state_t next_state(input tap_state_t state, input logic tms);
        tap_state_t nxt;
        case (state)
            TEST_RESET: nxt = tms ? TEST_RESET : RUN_IDLE;
            RUN_IDLE:   nxt = tms ? SELECT_DR  : RUN_IDLE;
            SELECT_DR:  nxt = tms ? SELECT_IR  : CAPTURE_DR;
            CAPTURE_DR: nxt = tms ? EXIT1_DR   : SHIFT_DR;
            SHIFT_DR:   nxt = tms ? EXIT1_DR   : SHIFT_DR;
            EXIT1_DR:   nxt = tms ? UPDATE_DR  : PAUSE_DR;
            PAUSE_DR:   nxt = tms ? EXIT2_DR   : PAUSE_DR;
            EXIT2_DR:   nxt = tms ? UPDATE_DR  : SHIFT_DR;
            UPDATE_DR:  nxt = tms ? SELECT_DR  : RUN_IDLE;
            SELECT_IR:  nxt = tms ? TEST_RESET : CAPTURE_IR;
            CAPTURE_IR: nxt = tms ? EXIT1_IR   : SHIFT_IR;
            SHIFT_IR:   nxt = tms ? EXIT1_IR   : SHIFT_IR;
            EXIT1_IR:   nxt = tms ? UPDATE_IR  : PAUSE_IR;
            PAUSE_IR:   nxt = tms ? EXIT2_IR   : PAUSE_IR;
            EXIT2_IR:   nxt = tms ? UPDATE_IR  : SHIFT_IR;
            UPDATE_IR:  nxt = tms ? SELECT_DR  : RUN_IDLE;
            default:    nxt = TEST_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP state machine: state register plus one-hot decodes of the states whose
// actions the controller performs on the edge that leaves them.
//
//   state       | meaning
//   ------------+----------------------------------------------
//   TEST_RESET  | test logic reset, IR forced to IDCODE
//   RUN_IDLE    | idle between scans
//   SELECT_DR   | branch point: DR scan or on to SELECT_IR
//   CAPTURE_DR  | parallel load of the selected DR
//   SHIFT_DR    | selected DR shifts tdi -> tdo
//   EXIT1_DR    | leave shift, go to pause or update
//   PAUSE_DR    | hold DR contents mid-scan
//   EXIT2_DR    | resume shifting or go to update
//   UPDATE_DR   | latch DR into its parallel output
//   SELECT_IR   | branch point: IR scan or back to reset
//   CAPTURE_IR  | load 2'b01 pattern into IR shift register
//   SHIFT_IR    | IR shift register shifts tdi -> tdo
//   EXIT1_IR    | leave shift, go to pause or update
//   PAUSE_IR    | hold IR shift contents mid-scan
//   EXIT2_IR    | resume shifting or go to update
//   UPDATE_IR   | IR shift register becomes the instruction
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       tck,
    input  logic       trst,
    input  logic       tms,
    output logic [3:0] state,
    output logic       is_capture_dr,
    output logic       is_shift_dr,
    output logic       is_update_dr,
    output logic       is_capture_ir,
    output logic       is_shift_ir,
    output logic       is_update_ir,
    output logic       is_tlr
);

    tap_state_t state_q;
    tap_state_t state_d;

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            state_q <= TEST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = next_state(state_q, tms);
        is_capture_dr = 1'b0;
        is_shift_dr   = 1'b0;
        is_update_dr  = 1'b0;
        is_capture_ir = 1'b0;
        is_shift_ir   = 1'b0;
        is_update_ir  = 1'b0;
        is_tlr        = 1'b0;
        case (state_q)
            CAPTURE_DR: is_capture_dr = 1'b1;
            SHIFT_DR:   is_shift_dr   = 1'b1;
            UPDATE_DR:  is_update_dr  = 1'b1;
            CAPTURE_IR: is_capture_ir = 1'b1;
            SHIFT_IR:   is_shift_ir   = 1'b1;
            UPDATE_IR:  is_update_ir  = 1'b1;
            TEST_RESET: is_tlr        = 1'b1;
            default:    ;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: instruction register, IDCODE/BYPASS/USER data registers,
// the TDO mux and the USER capture/update port toward on-chip debug logic.
module jtag_tap_ctrl
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH     = DEFAULT_IR_WIDTH,
    parameter logic [31:0]           IDCODE_VALUE = DEFAULT_IDCODE,
    parameter int                    USER_WIDTH   = DEFAULT_USER_WIDTH,
    parameter logic [IR_WIDTH-1:0]   OP_IDCODE    = IR_WIDTH'(DEFAULT_OP_IDCODE),
    parameter logic [IR_WIDTH-1:0]   OP_USER      = IR_WIDTH'(DEFAULT_OP_USER)
) (
    input  logic                  tck,
    input  logic                  trst,
    input  logic                  tms,
    input  logic                  tdi,
    output logic                  tdo,
    output logic                  tdo_en,
    output logic                  in_reset,
    output logic [3:0]            tap_state,
    output logic [IR_WIDTH-1:0]   ir_value,
    input  logic [USER_WIDTH-1:0] user_capture_data,
    output logic [USER_WIDTH-1:0] user_update_data,
    output logic                  user_update
);

    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    logic is_capture_dr;
    logic is_shift_dr;
    logic is_update_dr;
    logic is_capture_ir;
    logic is_shift_ir;
    logic is_update_ir;
    logic is_tlr;

    jtag_tap_fsm u_fsm (
        .tck           (tck),
        .trst          (trst),
        .tms           (tms),
        .state         (tap_state),
        .is_capture_dr (is_capture_dr),
        .is_shift_dr   (is_shift_dr),
        .is_update_dr  (is_update_dr),
        .is_capture_ir (is_capture_ir),
        .is_shift_ir   (is_shift_ir),
        .is_update_ir  (is_update_ir),
        .is_tlr        (is_tlr)
    );

    logic [IR_WIDTH-1:0]     ir_sr;
    logic [IR_WIDTH-1:0]     ir_q;
    logic [IDCODE_WIDTH-1:0] idcode_sr;
    logic [USER_WIDTH-1:0]   user_sr;
    logic [USER_WIDTH-1:0]   user_sr_shifted;
    logic                    bypass_sr;
    dr_sel_t                 dr_sel;

    // Instruction register: shift stage plus the live instruction.
    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            ir_sr <= '0;
            ir_q  <= OP_IDCODE;
        end else begin
            if (is_capture_ir) begin
                ir_sr <= IR_CAPTURE;
            end else if (is_shift_ir) begin
                ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            end
            if (is_tlr) begin
                ir_q <= OP_IDCODE;
            end else if (is_update_ir) begin
                ir_q <= ir_sr;
            end
        end
    end

    // An all-ones OP_USER would collide with the mandatory BYPASS opcode; BYPASS wins.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if ((ir_q == OP_USER) && (ir_q != '1)) begin
            dr_sel = DR_USER;
        end
    end

    // Written as a loop so a 1-bit USER register needs no special case.
    always_comb begin
        user_sr_shifted = '0;
        for (int i = 0; i < USER_WIDTH - 1; i++) begin
            user_sr_shifted[i] = user_sr[i+1];
        end
        user_sr_shifted[USER_WIDTH-1] = tdi;
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            idcode_sr <= '0;
            user_sr   <= '0;
            bypass_sr <= 1'b0;
        end else if (is_capture_dr) begin
            case (dr_sel)
                DR_IDCODE: idcode_sr <= IDCODE_VALUE;
                DR_USER:   user_sr   <= user_capture_data;
                default:   bypass_sr <= 1'b0;
            endcase
        end else if (is_shift_dr) begin
            case (dr_sel)
                DR_IDCODE: idcode_sr <= {tdi, idcode_sr[IDCODE_WIDTH-1:1]};
                DR_USER:   user_sr   <= user_sr_shifted;
                default:   bypass_sr <= tdi;
            endcase
        end
    end

    always_ff @(posedge tck or posedge trst) begin
        if (trst) begin
            user_update_data <= '0;
            user_update      <= 1'b0;
        end else begin
            user_update <= 1'b0;
            if (is_update_dr && (dr_sel == DR_USER)) begin
                user_update_data <= user_sr;
                user_update      <= 1'b1;
            end
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (is_shift_ir) begin
            tdo = ir_sr[0];
        end else if (is_shift_dr) begin
            case (dr_sel)
                DR_IDCODE: tdo = idcode_sr[0];
                DR_USER:   tdo = user_sr[0];
                default:   tdo = bypass_sr;
            endcase
        end
    end

    assign tdo_en   = is_shift_dr | is_shift_ir;
    assign in_reset = is_tlr;
    assign ir_value = ir_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IDCODE, IR capture, BYPASS, USER
// capture/update, pause re-entry, over-length shifts and trst mid-scan.
module tb_jtag_tap_ctrl;

    logic       tck;
    logic       trst;
    logic       tms;
    logic       tdi;
    logic       tdo;
    logic       tdo_en;
    logic       in_reset;
    logic [3:0] tap_state;
    logic [3:0] ir_value;
    logic [7:0] user_capture_data;
    logic [7:0] user_update_data;
    logic       user_update;

    int n_cmp = 0;
    int n_err = 0;

    jtag_tap_ctrl dut (
        .tck               (tck),
        .trst              (trst),
        .tms               (tms),
        .tdi               (tdi),
        .tdo               (tdo),
        .tdo_en            (tdo_en),
        .in_reset          (in_reset),
        .tap_state         (tap_state),
        .ir_value          (ir_value),
        .user_capture_data (user_capture_data),
        .user_update_data  (user_update_data),
        .user_update       (user_update)
    );

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge tck);
        #1;
    endtask

    // Samples tdo before each edge; tms goes high on the last bit to exit the shift state.
    task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
        dout = '0;
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            step(i == n - 1, din[i]);
        end
    endtask

    task automatic ir_scan(input logic [3:0] instr, output logic [3:0] cap);
        logic [63:0] d;
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        shift_bits(4, {60'd0, instr}, d);
        step(1, 0);
        step(0, 0);
        cap = d[3:0];
    endtask

    // upd = {user_update in 2nd RTI cycle, in 1st RTI cycle, while in UpdateDr}
    task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout,
                           output logic [2:0] upd);
        step(1, 0);
        step(0, 0);
        step(0, 0);
        shift_bits(n, din, dout);
        step(1, 0);
        upd[0] = user_update;
        step(0, 0);
        upd[1] = user_update;
        step(0, 0);
        upd[2] = user_update;
    endtask

    logic [63:0] dout;
    logic [63:0] d_lo;
    logic [63:0] d_hi;
    logic [3:0]  cap;
    logic [2:0]  upd;

    initial begin
        trst = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        user_capture_data = 8'h00;
        repeat (2) @(posedge tck);
        #1;
        check("rst_state", 64'(tap_state), 64'hF);
        check("rst_ir", 64'(ir_value), 64'h1);
        check("rst_tdo_en", 64'(tdo_en), 64'h0);
        check("rst_in_reset", 64'(in_reset), 64'h1);
        check("rst_upd", 64'(user_update), 64'h0);
        check("rst_upd_data", 64'(user_update_data), 64'h0);
        trst = 1'b0;

        step(0, 0);
        check("rti_state", 64'(tap_state), 64'hC);
        repeat (5) step(1, 0);
        check("tms5_tlr", 64'(tap_state), 64'hF);

        // IDCODE read straight after reset.
        step(0, 0);
        dr_scan(32, 64'd0, dout, upd);
        check("idcode", dout[31:0], 64'h0000_FAF1);
        check("idcode_no_upd", 64'(upd), 64'h0);

        // BYPASS via all-ones.
        ir_scan(4'hF, cap);
        check("ir_capture", 64'(cap), 64'h1);
        check("ir_bypass", 64'(ir_value), 64'hF);
        dr_scan(4, 64'b1101, dout, upd);
        check("bypass_f", dout[3:0], 64'b1010);
        check("bypass_f_no_upd", 64'(upd), 64'h0);

        // USER capture/update.
        ir_scan(4'h2, cap);
        check("ir_user", 64'(ir_value), 64'h2);
        user_capture_data = 8'h3C;
        dr_scan(8, 64'hA5, dout, upd);
        check("user_capture", dout[7:0], 64'h3C);
        check("user_upd_pulse", 64'(upd), 64'b010);
        check("user_upd_data", 64'(user_update_data), 64'hA5);

        // Pause/Exit2 re-entry continues the same scan without re-capture.
        user_capture_data = 8'h96;
        step(1, 0);
        step(0, 0);
        step(0, 0);
        check("shift_dr_state", 64'(tap_state), 64'h2);
        check("shift_dr_tdo_en", 64'(tdo_en), 64'h1);
        shift_bits(4, 64'hA, d_lo);
        step(0, 0);
        step(0, 0);
        check("pause_dr_state", 64'(tap_state), 64'h3);
        step(1, 0);
        step(0, 0);
        user_capture_data = 8'h00;
        shift_bits(4, 64'h5, d_hi);
        step(1, 0);
        step(0, 0);
        check("pause_capture", 64'({d_hi[3:0], d_lo[3:0]}), 64'h96);
        check("pause_upd_data", 64'(user_update_data), 64'h5A);
        step(0, 0);

        // Over-length shift: register behaves as an 8-stage delay line.
        user_capture_data = 8'h3C;
        dr_scan(12, 64'hABC, dout, upd);
        check("overlen_tdo", dout[11:0], 64'hC3C);
        check("overlen_upd_data", 64'(user_update_data), 64'hAB);

        // Undefined opcode acts as BYPASS and never updates USER.
        ir_scan(4'h7, cap);
        check("ir_undef_cap", 64'(cap), 64'h1);
        check("ir_undef", 64'(ir_value), 64'h7);
        dr_scan(4, 64'b0110, dout, upd);
        check("bypass_7", dout[3:0], 64'b1100);
        check("bypass_7_no_upd", 64'(upd), 64'h0);
        check("bypass_7_data_held", 64'(user_update_data), 64'hAB);

        // trst mid-ShiftDr.
        step(1, 0);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        step(0, 1);
        #2 trst = 1'b1;
        #1;
        check("trst_state", 64'(tap_state), 64'hF);
        check("trst_ir", 64'(ir_value), 64'h1);
        check("trst_tdo_en", 64'(tdo_en), 64'h0);
        check("trst_tdo", 64'(tdo), 64'h0);
        check("trst_upd_data", 64'(user_update_data), 64'h0);
        @(posedge tck);
        #1;
        trst = 1'b0;
        step(1, 0);
        check("post_trst_tlr", 64'(tap_state), 64'hF);
        check("post_trst_in_reset", 64'(in_reset), 64'h1);
        step(0, 0);
        dr_scan(32, 64'hFFFF_FFFF, dout, upd);
        check("post_trst_idcode", dout[31:0], 64'h0000_FAF1);

        // Five tms=1 from deep in the IR column.
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(1, 0);
        step(0, 0);
        check("pause_ir_state", 64'(tap_state), 64'hB);
        repeat (4) step(1, 0);
        check("four_ones_sel_ir", 64'(tap_state), 64'h4);
        step(1, 0);
        check("five_ones_tlr", 64'(tap_state), 64'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
